sata_link_tx_scheduler: RTL and testbench

// - Owns the link-layer transmit path and shares it between the link write side and the link read side.
// - Grants the path to one side at a time, applies SATA host/device collision rules, and drives SYNC when no side owns the path.
// - Optionally inserts periodic ALIGN pairs, gating the granted side's phy_ready so it stalls cleanly.
// - Sits between the write/read link engines and the phy TX interface.

---
 rtl/sata_link_tx_scheduler.sv | 160 ++++++++++++++++
 tb/tb_sata_link_tx_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sata_link_tx_scheduler.sv
// Link-layer TX path arbiter: grants the phy TX dword stream to the write or read engine.
// Define SATA_ALIGN_INSERT_EN to insert periodic ALIGN bursts into the stream.
module sata_link_tx_scheduler #(
    parameter int ALIGN_INTERVAL = 256,
    parameter int ALIGN_BURST    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic        is_device,
    input  logic        send_sync_escape,
    input  logic        write_request,
    input  logic        detect_x_rdy,
    input  logic        wr_idle,
    input  logic [31:0] wr_tx_dout,
    input  logic        wr_tx_isk,
    input  logic        rd_idle,
    input  logic [31:0] rd_tx_dout,
    input  logic        rd_tx_isk,
    output logic        write_en,
    output logic        read_en,
    output logic        side_phy_ready,
    output logic [31:0] tx_dout,
    output logic        tx_isk,
    output logic        align_active,
    output logic [1:0]  grant
);
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_WRITE = 2'd1,
        GRANT_READ  = 2'd2
    } grant_t;

    grant_t      state;
    grant_t      state_next;
    logic        busy_seen;
    logic        owner_idle;
    logic        hold;
    logic [31:0] mux_dout;
    logic        mux_isk;

    if (ALIGN_INTERVAL < 4 || ALIGN_INTERVAL > 4095 || ALIGN_BURST < 1 || ALIGN_BURST > 4) begin : g_param_check
        $error("sata_link_tx_scheduler: ALIGN_INTERVAL/ALIGN_BURST out of range");
    end

`ifdef SATA_ALIGN_INSERT_EN
    localparam logic [11:0] CNT_LAST  = 12'(ALIGN_INTERVAL - 1);
    localparam logic [2:0]  BURST_LEN = 3'(ALIGN_BURST);

    logic [11:0] dword_cnt;
    logic [2:0]  burst_cnt;

    // A burst is armed when the dword sent at count CNT_LAST leaves, so
    // exactly ALIGN_INTERVAL dwords precede each burst.
    assign hold = (burst_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || !phy_ready) begin
            dword_cnt <= '0;
            burst_cnt <= '0;
        end else if (send_sync_escape) begin
            burst_cnt <= '0;
            if (dword_cnt != CNT_LAST) dword_cnt <= dword_cnt + 12'd1;
        end else if (hold) begin
            burst_cnt <= burst_cnt - 3'd1;
        end else if (dword_cnt == CNT_LAST) begin
            dword_cnt <= '0;
            burst_cnt <= BURST_LEN;
        end else begin
            dword_cnt <= dword_cnt + 12'd1;
        end
    end
`else
    assign hold = 1'b0;
`endif

    assign owner_idle = (state == GRANT_WRITE) ? wr_idle : rd_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GRANT_NONE;
            busy_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (state == GRANT_NONE) busy_seen <= 1'b0;
            else if (!owner_idle)    busy_seen <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (!phy_ready || send_sync_escape) begin
            state_next = GRANT_NONE;
        end else if (!hold) begin
            case (state)
                GRANT_NONE: begin
                    if (detect_x_rdy && (!is_device || !write_request))
                        state_next = GRANT_READ;
                    else if (write_request && wr_idle && rd_idle)
                        state_next = GRANT_WRITE;
                end
                GRANT_WRITE, GRANT_READ: begin
                    if (owner_idle && busy_seen) state_next = GRANT_NONE;
                end
                default: state_next = GRANT_NONE;
            endcase
        end
    end

    always_comb begin
        grant    = state;
        write_en = (state == GRANT_WRITE);
        read_en  = (state == GRANT_READ);
        mux_dout = PRIM_SYNC;
        mux_isk  = 1'b1;
        case (state)
            GRANT_WRITE: begin
                mux_dout = wr_tx_dout;
                mux_isk  = wr_tx_isk;
            end
            GRANT_READ: begin
                mux_dout = rd_tx_dout;
                mux_isk  = rd_tx_isk;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_dout        <= PRIM_SYNC;
            tx_isk         <= 1'b1;
            align_active   <= 1'b0;
            side_phy_ready <= 1'b0;
        end else if (!phy_ready) begin
            tx_dout        <= PRIM_ALIGN;
            tx_isk         <= 1'b1;
            align_active   <= 1'b0;
            side_phy_ready <= 1'b0;
        end else if (send_sync_escape) begin
            tx_dout        <= PRIM_SYNC;
            tx_isk         <= 1'b1;
            align_active   <= 1'b0;
            side_phy_ready <= 1'b1;
        end else if (hold) begin
            tx_dout        <= PRIM_ALIGN;
            tx_isk         <= 1'b1;
            align_active   <= 1'b1;
            side_phy_ready <= 1'b0;
        end else begin
            tx_dout        <= mux_dout;
            tx_isk         <= mux_isk;
            align_active   <= 1'b0;
            side_phy_ready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sata_link_tx_scheduler.sv
// Self-checking bench for sata_link_tx_scheduler against a dword-level reference model.
// Honours SATA_ALIGN_INSERT_EN the same way the design does.
module tb_sata_link_tx_scheduler;
    localparam int INTERVAL = 8;
    localparam int BURST    = 2;
    localparam logic [31:0] SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
`ifdef SATA_ALIGN_INSERT_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, phy_ready, is_device, send_sync_escape;
    logic        write_request, detect_x_rdy, wr_idle, wr_tx_isk, rd_idle, rd_tx_isk;
    logic [31:0] wr_tx_dout, rd_tx_dout;
    logic        write_en, read_en, side_phy_ready, tx_isk, align_active;
    logic [31:0] tx_dout;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner (0 none, 1 write, 2 read), whether the owner
    // has been busy, dwords sent since the last ALIGN, ALIGN dwords still owed.
    int m_grant = 0;
    bit m_busy  = 1'b0;
    int m_since = 0;
    int m_owed  = 0;

    always #5 clk = ~clk;

    sata_link_tx_scheduler #(
        .ALIGN_INTERVAL(INTERVAL),
        .ALIGN_BURST(BURST)
    ) dut (
        .clk(clk), .rst(rst), .phy_ready(phy_ready), .is_device(is_device),
        .send_sync_escape(send_sync_escape), .write_request(write_request),
        .detect_x_rdy(detect_x_rdy), .wr_idle(wr_idle), .wr_tx_dout(wr_tx_dout),
        .wr_tx_isk(wr_tx_isk), .rd_idle(rd_idle), .rd_tx_dout(rd_tx_dout),
        .rd_tx_isk(rd_tx_isk), .write_en(write_en), .read_en(read_en),
        .side_phy_ready(side_phy_ready), .tx_dout(tx_dout), .tx_isk(tx_isk),
        .align_active(align_active), .grant(grant)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic int arbitrate(input int g, input bit busy);
        bit idle;
        idle = (g == 1) ? wr_idle : rd_idle;
        if (g == 0) begin
            if (detect_x_rdy && (!is_device || !write_request)) return 2;
            if (write_request && wr_idle && rd_idle) return 1;
            return 0;
        end
        return (idle && busy) ? 0 : g;
    endfunction

    // One clock: predict from the current inputs, clock, then compare.
    task automatic step(input string tag);
        int          e_grant;
        logic [31:0] e_dout;
        logic        e_isk, e_align, e_side;
        bit          owner_idle;
        owner_idle = (m_grant == 1) ? wr_idle : rd_idle;
        e_grant = m_grant;
        e_dout  = SYNC;
        e_isk   = 1'b1;
        e_align = 1'b0;
        e_side  = phy_ready;
        if (rst) begin
            e_grant = 0; e_side = 1'b0;
            m_busy = 1'b0; m_since = 0; m_owed = 0;
        end else begin
            if (!phy_ready) begin
                e_grant = 0; e_dout = ALIGN; m_since = 0; m_owed = 0;
            end else if (send_sync_escape) begin
                e_grant = 0; m_owed = 0;
                if (m_since < INTERVAL - 1) m_since++;
            end else if (ALIGN_ON && m_owed > 0) begin
                e_dout = ALIGN; e_align = 1'b1; e_side = 1'b0; m_owed--;
            end else begin
                if (m_grant == 1) begin e_dout = wr_tx_dout; e_isk = wr_tx_isk; end
                if (m_grant == 2) begin e_dout = rd_tx_dout; e_isk = rd_tx_isk; end
                if (ALIGN_ON) begin
                    m_since++;
                    if (m_since == INTERVAL) begin m_since = 0; m_owed = BURST; end
                end
                e_grant = arbitrate(m_grant, m_busy);
            end
            if (m_grant == 0)     m_busy = 1'b0;
            else if (!owner_idle) m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        m_grant = e_grant;
        check({tag, ".grant"},          32'(grant),          32'(e_grant));
        check({tag, ".write_en"},       32'(write_en),       32'(e_grant == 1));
        check({tag, ".read_en"},        32'(read_en),        32'(e_grant == 2));
        check({tag, ".tx_dout"},        tx_dout,             e_dout);
        check({tag, ".tx_isk"},         32'(tx_isk),         32'(e_isk));
        check({tag, ".align_active"},   32'(align_active),   32'(e_align));
        check({tag, ".side_phy_ready"}, 32'(side_phy_ready), 32'(e_side));
    endtask

    // Write engine holds its dword while stalled by side_phy_ready.
    task automatic next_wr_word();
        if (side_phy_ready) begin
            wr_tx_dout = $urandom;
            wr_tx_isk  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        rst = 1'b1; phy_ready = 1'b1; is_device = 1'b0; send_sync_escape = 1'b0;
        write_request = 1'b0; detect_x_rdy = 1'b0; wr_idle = 1'b1; rd_idle = 1'b1;
        wr_tx_dout = 32'h1111_0000; wr_tx_isk = 1'b0;
        rd_tx_dout = 32'h2222_0000; rd_tx_isk = 1'b0;
        step("reset");
        step("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("idle_sync");

        // Host collision: READ wins, WRITE waits for a NONE cycle.
        write_request = 1'b1; detect_x_rdy = 1'b1;
        step("host_collision");
        detect_x_rdy = 1'b0; rd_idle = 1'b0;
        for (int i = 0; i < 4; i++) begin rd_tx_dout = $urandom; step("host_read_busy"); end
        rd_idle = 1'b1;
        for (int i = 0; i < 3; i++) step("host_read_release");

        // WRITE owner busy for 10 cycles then released.
        write_request = 1'b0; wr_idle = 1'b0;
        for (int i = 0; i < 10; i++) begin next_wr_word(); step("write_busy"); end
        wr_idle = 1'b1;
        for (int i = 0; i < 4; i++) step("write_release");

        // Device collision: WRITE wins.
        is_device = 1'b1; write_request = 1'b1; detect_x_rdy = 1'b1;
        step("device_collision");
        detect_x_rdy = 1'b0;
        step("device_write");

        // Continuous WRITE with ALIGN insertion and a stalling write engine.
        wr_idle = 1'b0;
        for (int i = 0; i < 30; i++) begin next_wr_word(); step("continuous_write"); end

        // Escape pulsed in the middle of an ALIGN burst (bounded wait).
        for (int i = 0; i < 3 * INTERVAL && !align_active; i++) begin
            next_wr_word(); step("wait_align");
        end
        send_sync_escape = 1'b1;
        step("escape");
        send_sync_escape = 1'b0;
        wr_idle = 1'b1; write_request = 1'b0;
        for (int i = 0; i < 3; i++) step("after_escape");

        // Reset asserted while WRITE is granted.
        write_request = 1'b1;
        for (int i = 0; i < 3; i++) step("regrant_write");
        wr_idle = 1'b0;
        step("write_running");
        rst = 1'b1;
        step("reset_mid_write");
        rst = 1'b0; wr_idle = 1'b1; write_request = 1'b0;

        // phy_ready loss forces ALIGN on the wire.
        phy_ready = 1'b0;
        step("phy_down");
        phy_ready = 1'b1;
        step("phy_up");

        for (int i = 0; i < 800; i++) begin
            rst              = ($urandom_range(0, 199) == 0);
            phy_ready        = ($urandom_range(0, 24) != 0);
            send_sync_escape = ($urandom_range(0, 39) == 0);
            is_device        = 1'($urandom_range(0, 1));
            write_request    = ($urandom_range(0, 2) == 0);
            detect_x_rdy     = ($urandom_range(0, 4) == 0);
            wr_idle          = ($urandom_range(0, 2) != 0);
            rd_idle          = ($urandom_range(0, 2) != 0);
            rd_tx_dout       = $urandom;
            rd_tx_isk        = 1'($urandom_range(0, 1));
            next_wr_word();
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
